// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with branch/jump decode, stall hold, exception redirect
// and a circular return-address stack for call/return.
module pc_unit_ras #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'('h40),
  parameter int unsigned      RAS_DEPTH  = 4,
  parameter bit               SIGNED_CMP = 1'b0
) (
  input  logic                         clk,
  input  logic                         rstd,
  input  logic                         stall,
  input  logic                         exc,
  input  logic [5:0]                   op,
  input  logic [WIDTH-1:0]             os,
  input  logic [WIDTH-1:0]             ot,
  input  logic [25:0]                  addr,
  input  logic [WIDTH-1:0]             imm_dpl,
  output logic [WIDTH-1:0]             pc,
  output logic                         taken,
  output logic [WIDTH-1:0]             link,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_uflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(RAS_DEPTH);

  localparam logic [5:0] OpBeq  = 6'd32;
  localparam logic [5:0] OpBne  = 6'd33;
  localparam logic [5:0] OpBlt  = 6'd34;
  localparam logic [5:0] OpBle  = 6'd35;
  localparam logic [5:0] OpJ    = 6'd40;
  localparam logic [5:0] OpJal  = 6'd41;
  localparam logic [5:0] OpJr   = 6'd42;
  localparam logic [5:0] OpRet  = 6'd43;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             taken_q, taken_d;
  logic             uflow_q, uflow_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] nonbranch, branch, dpl, jump_tgt, ras_top;
  logic [PtrW-1:0]  ptr_dec;
  logic             eq, lt, push;

  always_comb begin
    nonbranch = pc_q + WIDTH'(1);
    // Displacement arrives in bytes; the PC counts words.
    dpl       = $unsigned($signed(imm_dpl) >>> 2);
    branch    = nonbranch + dpl;
    jump_tgt  = WIDTH'({2'b00, addr[25:2]});
    ptr_dec   = ptr_q - PtrW'(1);
    ras_top   = ras_q[ptr_dec];
    eq        = (os == ot);
    if (SIGNED_CMP) lt = ($signed(os) < $signed(ot));
    else            lt = (os < ot);
  end

  always_comb begin
    pc_d    = pc_q;
    taken_d = taken_q;
    uflow_d = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (exc) begin
      pc_d    = EXC_VEC;
      taken_d = 1'b1;
      ptr_d   = '0;
      cnt_d   = '0;
    end else if (!stall) begin
      pc_d    = nonbranch;
      taken_d = 1'b0;
      unique case (op)
        OpBeq: if (eq)        begin pc_d = branch; taken_d = 1'b1; end
        OpBne: if (!eq)       begin pc_d = branch; taken_d = 1'b1; end
        OpBlt: if (lt)        begin pc_d = branch; taken_d = 1'b1; end
        OpBle: if (lt || eq)  begin pc_d = branch; taken_d = 1'b1; end
        OpJ: begin
          pc_d    = jump_tgt;
          taken_d = 1'b1;
        end
        OpJal: begin
          pc_d    = jump_tgt;
          taken_d = 1'b1;
          push    = 1'b1;
          ptr_d   = ptr_q + PtrW'(1);
          // A full stack overwrites its oldest entry, so the count just saturates.
          if (cnt_q != CntFull) cnt_d = cnt_q + 1'b1;
        end
        OpJr: begin
          pc_d    = os;
          taken_d = 1'b1;
        end
        OpRet: begin
          taken_d = 1'b1;
          if (cnt_q != '0) begin
            pc_d  = ras_top;
            ptr_d = ptr_dec;
            cnt_d = cnt_q - 1'b1;
          end else begin
            pc_d    = os;
            uflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      uflow_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      uflow_q <= uflow_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stack storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= nonbranch;
  end

  assign pc        = pc_q;
  assign taken     = taken_q;
  assign link      = nonbranch;
  assign ras_count = cnt_q;
  assign ras_uflow = uflow_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed vector table, signed-compare check and a randomized
// run against a queue-based reference model.
module tb_pc_unit_ras;

  logic        clk = 1'b0;
  logic        rstd;
  logic        stall, exc;
  logic [5:0]  op;
  logic [31:0] os, ot, imm_dpl;
  logic [25:0] addr;
  logic [31:0] pc, link, pc_s, link_s;
  logic        taken, ras_uflow, taken_s, ras_uflow_s;
  logic [2:0]  ras_count, ras_count_s;

  always #5 clk = ~clk;

  pc_unit_ras #(.SIGNED_CMP(1'b0)) dut (
    .clk(clk), .rstd(rstd), .stall(stall), .exc(exc), .op(op), .os(os), .ot(ot),
    .addr(addr), .imm_dpl(imm_dpl), .pc(pc), .taken(taken), .link(link),
    .ras_count(ras_count), .ras_uflow(ras_uflow)
  );

  pc_unit_ras #(.SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rstd(rstd), .stall(stall), .exc(exc), .op(op), .os(os), .ot(ot),
    .addr(addr), .imm_dpl(imm_dpl), .pc(pc_s), .taken(taken_s), .link(link_s),
    .ras_count(ras_count_s), .ras_uflow(ras_uflow_s)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] os, ot;
    logic [25:0] addr;
    logic [31:0] imm;
    logic        st, ex;
    logic [31:0] pc;
    logic        tk;
    logic [2:0]  cnt;
    logic        uf;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_tk, m_uf;
  logic [31:0] m_ras[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic [31:0] o, input logic [31:0] s, input logic [31:0] t,
                     input logic [31:0] a, input logic [31:0] im, input logic st,
                     input logic ex, input logic [31:0] epc, input logic etk,
                     input logic [31:0] ecnt, input logic euf);
    vec_t v;
    v.op = o[5:0]; v.os = s; v.ot = t; v.addr = a[25:0]; v.imm = im;
    v.st = st; v.ex = ex; v.pc = epc; v.tk = etk; v.cnt = ecnt[2:0]; v.uf = euf;
    vecs.push_back(v);
  endtask

  task automatic apply(input logic [5:0] o, input logic [31:0] s, input logic [31:0] t,
                       input logic [25:0] a, input logic [31:0] im, input logic st,
                       input logic ex);
    op = o; os = s; ot = t; addr = a; imm_dpl = im; stall = st; exc = ex;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstd = 1'b1;
    #1 check("async_reset_pc", pc, 32'd0);
    @(negedge clk);
    rstd = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] nb, npc;
    nb = m_pc + 32'd1;
    npc = nb;
    m_uf = 1'b0;
    if (exc) begin
      npc = 32'h40; m_tk = 1'b1; m_ras.delete();
    end else if (stall) begin
      npc = m_pc;
    end else begin
      m_tk = 1'b0;
      if ((op == 6'd32 && os == ot) || (op == 6'd33 && os != ot) ||
          (op == 6'd34 && os < ot) || (op == 6'd35 && os <= ot)) begin
        npc = nb + 32'($signed(imm_dpl) >>> 2); m_tk = 1'b1;
      end else if (op == 6'd40 || op == 6'd41) begin
        npc = {8'd0, addr[25:2]}; m_tk = 1'b1;
        if (op == 6'd41) begin
          m_ras.push_back(nb);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
      end else if (op == 6'd42) begin
        npc = os; m_tk = 1'b1;
      end else if (op == 6'd43) begin
        m_tk = 1'b1;
        if (m_ras.size() > 0) npc = m_ras.pop_back();
        else begin npc = os; m_uf = 1'b1; end
      end
    end
    m_pc = npc;
  endtask

  initial begin
    logic [5:0] ops [10];
    ops = '{6'd0, 6'd7, 6'd32, 6'd33, 6'd34, 6'd35, 6'd40, 6'd41, 6'd42, 6'd43};

    // op, os, ot, addr, imm, stall, exc -> pc, taken, ras_count, ras_uflow
    add(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
    add(42, 10, 0, 0, 0, 0, 0, 10, 1, 0, 0);
    add(32, 5, 5, 0, -8, 0, 0, 9, 1, 0, 0);
    add(42, 10, 0, 0, 0, 0, 0, 10, 1, 0, 0);
    add(32, 5, 6, 0, -8, 0, 0, 11, 0, 0, 0);
    add(33, 1, 2, 0, 16, 0, 0, 16, 1, 0, 0);
    add(35, 3, 3, 0, 4, 0, 0, 18, 1, 0, 0);
    add(34, 3, 3, 0, 4, 0, 0, 19, 0, 0, 0);
    add(40, 0, 0, 32'h3FF_FFFF, 0, 0, 0, 32'h00FF_FFFF, 1, 0, 0);
    add(42, 100, 0, 0, 0, 0, 0, 100, 1, 0, 0);
    add(41, 0, 0, 800, 0, 0, 0, 200, 1, 1, 0);
    add(41, 0, 0, 1200, 0, 0, 0, 300, 1, 2, 0);
    add(41, 0, 0, 1600, 0, 0, 0, 400, 1, 3, 0);
    add(41, 0, 0, 2000, 0, 0, 0, 500, 1, 4, 0);
    add(41, 0, 0, 4000, 0, 0, 0, 1000, 1, 4, 0);
    add(43, 0, 0, 0, 0, 0, 0, 501, 1, 3, 0);
    add(43, 0, 0, 0, 0, 0, 0, 401, 1, 2, 0);
    add(43, 0, 0, 0, 0, 0, 0, 301, 1, 1, 0);
    add(43, 0, 0, 0, 0, 0, 0, 201, 1, 0, 0);
    add(43, 77, 0, 0, 0, 0, 0, 77, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 78, 0, 0, 0);
    add(40, 0, 0, 4000, 0, 1, 0, 78, 0, 0, 0);
    add(40, 0, 0, 4000, 0, 1, 0, 78, 0, 0, 0);
    add(40, 0, 0, 4000, 0, 1, 0, 78, 0, 0, 0);
    add(41, 0, 0, 400, 0, 0, 0, 100, 1, 1, 0);
    add(43, 0, 0, 0, 0, 1, 0, 100, 1, 1, 0);
    add(41, 0, 0, 400, 0, 1, 1, 32'h40, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 32'h40, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h41, 0, 0, 0);
    add(42, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(42, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0);
    add(41, 0, 0, 40, 0, 0, 0, 10, 1, 1, 0);
    add(43, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    rstd = 1'b1; stall = 0; exc = 0; op = 0; os = 0; ot = 0; addr = 0; imm_dpl = 0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_count", {29'd0, ras_count}, 32'd0);
    check("rst_uflow", {31'd0, ras_uflow}, 32'd0);
    check("rst_link", link, 32'd1);
    #2 rstd = 1'b0;
    #1 check("release_no_glitch", pc, 32'd0);
    @(negedge clk);
    check("first_inc", pc, 32'd1);

    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].os, vecs[i].ot, vecs[i].addr, vecs[i].imm, vecs[i].st,
            vecs[i].ex);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].pc);
      check($sformatf("vec%0d_taken", i), {31'd0, taken}, {31'd0, vecs[i].tk});
      check($sformatf("vec%0d_count", i), {29'd0, ras_count}, {29'd0, vecs[i].cnt});
      check($sformatf("vec%0d_uflow", i), {31'd0, ras_uflow}, {31'd0, vecs[i].uf});
      check($sformatf("vec%0d_link", i), link, vecs[i].pc + 32'd1);
    end

    // Signed vs unsigned compare on the same operands
    do_reset();
    apply(6'd34, 32'hFFFF_FFFF, 32'd1, 26'd0, 32'd40, 1'b0, 1'b0);
    check("unsigned_blt_pc", pc, 32'd1);
    check("unsigned_blt_taken", {31'd0, taken}, 32'd0);
    check("signed_blt_pc", pc_s, 32'd11);
    check("signed_blt_taken", {31'd0, taken_s}, 32'd1);

    // Randomized run against the reference model
    do_reset();
    m_pc = 32'd0; m_tk = 1'b0; m_uf = 1'b0; m_ras.delete();
    for (int n = 0; n < 600; n++) begin
      op      = ops[$urandom_range(0, 9)];
      os      = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 3));
      ot      = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 3));
      addr    = 26'($urandom());
      imm_dpl = 32'($urandom_range(0, 63)) - 32'd32;
      stall   = ($urandom_range(0, 7) == 0);
      exc     = ($urandom_range(0, 23) == 0);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rnd%0d_pc", n), pc, m_pc);
      check($sformatf("rnd%0d_taken", n), {31'd0, taken}, {31'd0, m_tk});
      check($sformatf("rnd%0d_count", n), {29'd0, ras_count}, 32'(m_ras.size()));
      check($sformatf("rnd%0d_uflow", n), {31'd0, ras_uflow}, {31'd0, m_uf});
      check($sformatf("rnd%0d_link", n), link, m_pc + 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
